control_unit: RTL and testbench

Hardwired sequencer that drives the 32-bit `control_signal` word into the ALU and datapath registers (PC, MAR, MBR, IR, BR, ACC) and consumes the ALU's `flag` byte. It runs the fetch/decode/operand/execute/write-back cycle for the 16-bit accumulator CPU. While an ALU operation runs, it holds the ALU op bit steady for the ALU's multi-cycle latency, then commits the result to ACC.

---
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/operand/execute/write-back sequencer
// for the 16-bit accumulator CPU. Emits a 32-bit micro-operation word decoded
// from registered state, the current opcode and the EX hold counter.
module control_unit #(
  parameter int unsigned ALU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [7:0]  flag,
  output logic [31:0] control_signal,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_O0, S_O1, S_O2,
    S_EX, S_WB, S_LD, S_ST0, S_ST1, S_JP, S_HALT
  } state_t;

  localparam int unsigned B_PC_INC  = 0;
  localparam int unsigned B_PC_LOAD = 1;
  localparam int unsigned B_MAR_PC  = 2;
  localparam int unsigned B_MAR_IR  = 3;
  localparam int unsigned B_MEM_RD  = 4;
  localparam int unsigned B_MEM_WR  = 5;
  localparam int unsigned B_IR_LD   = 6;
  localparam int unsigned B_BR_LD   = 7;
  localparam int unsigned B_ACC_ALU = 8;
  localparam int unsigned B_MBR_ACC = 10;
  localparam int unsigned B_ACC_BR  = 11;

  // EX exits on counter == ALU_LAT-1, so the counter never needs to wrap.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic [7:0]  opcode;
  logic [31:0] alu_w;
  logic        unused_ir_flag;

  assign opcode         = ir[15:8];
  assign unused_ir_flag = ^{ir[7:0], flag[7:1]};

  // ALU op bit(s) selected by the opcode; MPY drives both product halves.
  always_comb begin
    alu_w = '0;
    case (opcode)
      8'h03: alu_w[22] = 1'b1;
      8'h04: alu_w[23] = 1'b1;
      8'h08: begin alu_w[29] = 1'b1; alu_w[16] = 1'b1; end
      8'h0A: alu_w[24] = 1'b1;
      8'h0B: alu_w[25] = 1'b1;
      8'h0C: alu_w[26] = 1'b1;
      8'h0D: alu_w[28] = 1'b1;
      8'h0E: alu_w[27] = 1'b1;
      8'h0F: alu_w[31] = 1'b1;
      8'h10: alu_w[30] = 1'b1;
      default: alu_w = '0;
    endcase
  end

  // Next-state, counter and micro-operation word decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_d         = load_q;
    control_signal = '0;
    illegal        = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_F0;
      S_F0: begin
        control_signal[B_MAR_PC] = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        control_signal[B_MEM_RD] = 1'b1;
        control_signal[B_PC_INC] = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        control_signal[B_IR_LD] = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          8'h00: state_d = S_F0;
          8'h01: state_d = S_ST0;
          8'h02: begin load_d = 1'b1; state_d = S_O0; end
          8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B: begin
            load_d  = 1'b0;
            state_d = S_O0;
          end
          8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10: begin
            cnt_d   = '0;
            state_d = S_EX;
          end
          8'h05: state_d = flag[0] ? S_F0 : S_JP;
          8'h06: state_d = S_JP;
          8'h07: state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = S_F0;
          end
        endcase
      end
      S_O0: begin
        control_signal[B_MAR_IR] = 1'b1;
        state_d = S_O1;
      end
      S_O1: begin
        control_signal[B_MEM_RD] = 1'b1;
        state_d = S_O2;
      end
      // Operand-path choice is latched in DECODE so IR is not re-sampled here.
      S_O2: begin
        control_signal[B_BR_LD] = 1'b1;
        if (load_q) begin
          state_d = S_LD;
        end else begin
          cnt_d   = '0;
          state_d = S_EX;
        end
      end
      S_EX: begin
        control_signal = alu_w;
        if (cnt_q == LAT_M1) begin
          cnt_d   = '0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        control_signal[B_ACC_ALU] = 1'b1;
        state_d = S_F0;
      end
      S_LD: begin
        control_signal[B_ACC_BR] = 1'b1;
        state_d = S_F0;
      end
      S_ST0: begin
        control_signal[B_MAR_IR]  = 1'b1;
        control_signal[B_MBR_ACC] = 1'b1;
        state_d = S_ST1;
      end
      S_ST1: begin
        control_signal[B_MEM_WR] = 1'b1;
        state_d = S_F0;
      end
      S_JP: begin
        control_signal[B_PC_LOAD] = 1'b1;
        state_d = S_F0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

  // State, EX counter and operand-path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (ALU_LAT=3 and ALU_LAT=1) driven by
// directed and random instruction streams, checked cycle by cycle against a
// per-instruction expected word sequence built from the opcode table.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [15:0] ir;
  logic [7:0]  flag;
  logic [31:0] cs0, cs1;
  logic        busy0, busy1, halted0, halted1, ill0, ill1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_unit #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start0), .ir(ir), .flag(flag),
    .control_signal(cs0), .busy(busy0), .halted(halted0), .illegal(ill0)
  );

  control_unit #(.ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .ir(ir), .flag(flag),
    .control_signal(cs1), .busy(busy1), .halted(halted1), .illegal(ill1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_word(input logic [7:0] op);
    case (op)
      8'h03: return 32'h0040_0000;
      8'h04: return 32'h0080_0000;
      8'h08: return 32'h2001_0000;
      8'h0A: return 32'h0100_0000;
      8'h0B: return 32'h0200_0000;
      8'h0C: return 32'h0400_0000;
      8'h0D: return 32'h1000_0000;
      8'h0E: return 32'h0800_0000;
      8'h0F: return 32'h8000_0000;
      8'h10: return 32'h4000_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [34:0] observe(input int which);
    if (which == 0) return {cs0, busy0, halted0, ill0};
    return {cs1, busy1, halted1, ill1};
  endfunction

  // Called one step after the edge that entered F0; returns one step after
  // the edge that enters the next F0 (or after a few HALT cycles).
  task automatic run_instr(input int which, input int lat, input logic [7:0] op,
                           input logic [7:0] addr, input logic fl0);
    logic [31:0] q[$];
    logic [34:0] o;
    logic [31:0] w;
    logic        legal;
    w     = alu_word(op);
    legal = 1'b1;
    q     = {32'h4, 32'h11, 32'h40, 32'h0};
    case (op)
      8'h00: ;
      8'h01: begin q.push_back(32'h408); q.push_back(32'h20); end
      8'h02: begin q.push_back(32'h8); q.push_back(32'h10); q.push_back(32'h80); q.push_back(32'h800); end
      8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B: begin
        q.push_back(32'h8); q.push_back(32'h10); q.push_back(32'h80);
        repeat (lat) q.push_back(w);
        q.push_back(32'h100);
      end
      8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10: begin
        repeat (lat) q.push_back(w);
        q.push_back(32'h100);
      end
      8'h05: if (!fl0) q.push_back(32'h2);
      8'h06: q.push_back(32'h2);
      8'h07: ;
      default: legal = 1'b0;
    endcase
    ir = {op, addr};
    foreach (q[i]) begin
      flag = 8'($urandom);
      if (i == 3) flag[0] = fl0;
      if (which == 0) start0 = 1'($urandom);
      else            start1 = 1'($urandom);
      o = observe(which);
      check($sformatf("d%0d op%02h c%0d word", which, op, i), o[34:3], q[i]);
      check($sformatf("d%0d op%02h c%0d busy", which, op, i), {31'b0, o[2]}, 32'd1);
      check($sformatf("d%0d op%02h c%0d halted", which, op, i), {31'b0, o[1]}, 32'd0);
      check($sformatf("d%0d op%02h c%0d illegal", which, op, i), {31'b0, o[0]},
            {31'b0, (i == 3 && !legal)});
      @(posedge clk); #1;
    end
    if (op == 8'h07) begin
      repeat (4) begin
        if (which == 0) start0 = ~start0;
        else            start1 = ~start1;
        o = observe(which);
        check($sformatf("d%0d halt word", which), o[34:3], 32'h0);
        check($sformatf("d%0d halt busy", which), {31'b0, o[2]}, 32'd0);
        check($sformatf("d%0d halt halted", which), {31'b0, o[1]}, 32'd1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic random_program(input int which, input int lat, input int n);
    logic [7:0] ops[15] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08,
                            8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    logic [7:0] op;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(8'h11, 8'hFF));
      else                           op = ops[$urandom_range(0, 14)];
      run_instr(which, lat, op, 8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; ir = '0; flag = '0;
    #12;
    check("rst word", cs0, 32'h0);
    check("rst busy", {31'b0, busy0}, 32'd0);
    check("rst halted", {31'b0, halted0}, 32'd0);
    check("rst illegal", {31'b0, ill0}, 32'd0);
    rst = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;

    // Directed ALU_LAT=3 sequences.
    run_instr(0, 3, 8'h00, 8'h00, 1'b0);
    run_instr(0, 3, 8'h03, 8'h12, 1'b0);
    run_instr(0, 3, 8'h08, 8'h20, 1'b0);
    run_instr(0, 3, 8'h0C, 8'h00, 1'b0);
    run_instr(0, 3, 8'h05, 8'h40, 1'b0);
    run_instr(0, 3, 8'h05, 8'h40, 1'b1);
    run_instr(0, 3, 8'hFF, 8'h00, 1'b0);
    run_instr(0, 3, 8'h01, 8'h33, 1'b0);
    run_instr(0, 3, 8'h02, 8'h44, 1'b1);
    random_program(0, 3, 40);

    // Asynchronous reset during the second EX cycle of SUB.
    ir = 16'h0430;
    repeat (8) @(posedge clk);
    #2;
    check("sub ex2 word", cs0, 32'h0080_0000);
    #2 rst = 1'b0;
    #1;
    check("async rst word", cs0, 32'h0);
    check("async rst busy", {31'b0, busy0}, 32'd0);
    check("async rst halted", {31'b0, halted0}, 32'd0);
    @(posedge clk); #1;
    check("rst held word", cs0, 32'h0);
    rst = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    run_instr(0, 3, 8'h04, 8'h30, 1'b0);
    run_instr(0, 3, 8'h07, 8'h00, 1'b0);

    // ALU_LAT=1 instance: idle until now since its start was never raised.
    check("lat1 idle word", cs1, 32'h0);
    check("lat1 idle busy", {31'b0, busy1}, 32'd0);
    start1 = 1'b1;
    @(posedge clk); #1;
    run_instr(1, 1, 8'h03, 8'h12, 1'b0);
    run_instr(1, 1, 8'h0C, 8'h00, 1'b0);
    run_instr(1, 1, 8'h08, 8'h20, 1'b0);
    random_program(1, 1, 30);
    run_instr(1, 1, 8'h07, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
